clk_div_meter: RTL and testbench

- Measures the output of the clock dividers in this codebase, such as the odd-ratio divider.
- Samples the divided clock as an asynchronous input in the system clock domain and counts its high time and low time in system clock cycles.
- Reports one high/low/period result per divided-clock period, with a one-cycle valid strobe.
- Sits directly downstream of a divider. It is used for on-chip self-check of divide ratio and duty cycle, and by benches to confirm divider behaviour.

---
 rtl/clk_div_meter.sv | 172 +++++++++++++++++
 tb/tb_clk_div_meter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_meter.sv
// rtl/clk_div_meter.sv - measures high, low and period length of a divided clock in clk cycles
//
// Purpose: synchronizes an asynchronous divided clock (sig_in) into the clk
// domain and counts its high and low phases. One result per divided-clock
// period (rise to rise), with a one-cycle valid strobe.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   sig_in      divided clock under measurement, asynchronous to clk
//   meas_en     level enable; low aborts and holds the FSM in IDLE
//   high_cnt    high-phase length of the last completed period
//   low_cnt     low-phase length of the last completed period
//   period_cnt  high_cnt + low_cnt, one bit wider so it never wraps
//   ovf         a counter saturated during the last completed period
//   valid       one-cycle strobe; the result outputs update in the same cycle

module clk_div_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             ovf,
    output logic             valid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;
    logic                   rise;
    logic                   fall;

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic             ovf_acc;

    logic clr_cnt;
    logic start_high;
    logic to_low;
    logic done;
    logic inc_high;
    logic inc_low;

    // Synchronizer plus one history flop. Rise and fall both come out of the
    // same chain, so they carry identical latency and phase lengths are exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev <= s_sync;
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;
    assign fall   = ~s_sync & s_prev;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a low enable overrides every transition, including a
    // rise that would otherwise close a period.
    always_comb begin
        state_d = state_q;
        if (!meas_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = WAIT_RISE;
                WAIT_RISE: if (rise) state_d = MEAS_HIGH;
                MEAS_HIGH: if (fall) state_d = MEAS_LOW;
                MEAS_LOW:  if (rise) state_d = MEAS_HIGH;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Output decode: datapath controls derived from state and edge events.
    always_comb begin
        clr_cnt    = 1'b0;
        start_high = 1'b0;
        to_low     = 1'b0;
        done       = 1'b0;
        inc_high   = 1'b0;
        inc_low    = 1'b0;
        case (state_q)
            IDLE:      clr_cnt    = 1'b1;
            WAIT_RISE: start_high = meas_en & rise;
            MEAS_HIGH: begin
                to_low   = meas_en & fall;
                inc_high = meas_en & ~fall;
            end
            MEAS_LOW: begin
                done    = meas_en & rise;
                inc_low = meas_en & ~rise;
            end
            default:   clr_cnt    = 1'b1;
        endcase
    end

    // Phase counters. The edge cycle itself counts as the first cycle of the
    // new phase, which is why a phase starts at 1 rather than 0.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            hcnt    <= '0;
            lcnt    <= '0;
            ovf_acc <= 1'b0;
        end else if (start_high || done) begin
            hcnt    <= CNT_W'(1);
            lcnt    <= '0;
            ovf_acc <= 1'b0;
        end else if (to_low) begin
            lcnt <= CNT_W'(1);
        end else if (inc_high) begin
            if (&hcnt) begin
                ovf_acc <= 1'b1;
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end else if (inc_low) begin
            if (&lcnt) begin
                ovf_acc <= 1'b1;
            end else begin
                lcnt <= lcnt + CNT_W'(1);
            end
        end
    end

    // Result registers: only a completed period (or reset) changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt   <= '0;
            low_cnt    <= '0;
            period_cnt <= '0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= done;
            if (done) begin
                high_cnt   <= hcnt;
                low_cnt    <= lcnt;
                period_cnt <= {1'b0, hcnt} + {1'b0, lcnt};
                ovf        <= ovf_acc;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_meter.sv
// tb/tb_clk_div_meter.sv - directed self-checking bench for clk_div_meter

module tb_clk_div_meter;

    typedef struct {
        int cyc;
        int h;
        int l;
        int p;
        int o;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic meas_en = 1'b0;

    logic [15:0] a_high, a_low;
    logic [16:0] a_period;
    logic        a_ovf, a_valid;
    logic [3:0]  b_high, b_low;
    logic [4:0]  b_period;
    logic        b_ovf, b_valid;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    rec_t qa[$];
    rec_t qb[$];
    int   rise_q[$];

    clk_div_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
        .high_cnt(a_high), .low_cnt(a_low), .period_cnt(a_period),
        .ovf(a_ovf), .valid(a_valid)
    );

    clk_div_meter #(.CNT_W(4), .SYNC_STAGES(3)) u_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
        .high_cnt(b_high), .low_cnt(b_low), .period_cnt(b_period),
        .ovf(b_ovf), .valid(b_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t mk_rec(input int c, input int h, input int l, input int p, input int o);
        rec_t r;
        r.cyc = c;
        r.h   = h;
        r.l   = l;
        r.p   = p;
        r.o   = o;
        return r;
    endfunction

    always @(negedge clk) begin
        if (a_valid) qa.push_back(mk_rec(cyc, int'(a_high), int'(a_low), int'(a_period), int'(a_ovf)));
        if (b_valid) qb.push_back(mk_rec(cyc, int'(b_high), int'(b_low), int'(b_period), int'(b_ovf)));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rise is sampled at the next posedge, i.e. edge cyc+1.
    task automatic drive_period(input int h, input int l);
        rise_q.push_back(cyc + 1);
        sig_in = 1'b1;
        tick(h);
        sig_in = 1'b0;
        tick(l);
    endtask

    task automatic restart();
        meas_en = 1'b0;
        sig_in  = 1'b0;
        tick(3);
        qa.delete();
        qb.delete();
        rise_q.delete();
        meas_en = 1'b1;
        tick(2);
    endtask

    task automatic check_rec(input string tag, input rec_t r, input int h, input int l, input int p, input int o);
        check({tag, "_high"}, r.h, h);
        check({tag, "_low"}, r.l, l);
        check({tag, "_period"}, r.p, p);
        check({tag, "_ovf"}, r.o, o);
    endtask

    task automatic check_outputs_a(input string tag, input int h, input int l, input int p, input int o, input int v);
        check({tag, "_a_high"}, int'(a_high), h);
        check({tag, "_a_low"}, int'(a_low), l);
        check({tag, "_a_period"}, int'(a_period), p);
        check({tag, "_a_ovf"}, int'(a_ovf), o);
        check({tag, "_a_valid"}, int'(a_valid), v);
    endtask

    task automatic check_outputs_b(input string tag, input int h, input int l, input int p, input int o, input int v);
        check({tag, "_b_high"}, int'(b_high), h);
        check({tag, "_b_low"}, int'(b_low), l);
        check({tag, "_b_period"}, int'(b_period), p);
        check({tag, "_b_ovf"}, int'(b_ovf), o);
        check({tag, "_b_valid"}, int'(b_valid), v);
    endtask

    initial begin
        bit p_ph;
        bit n_ph;

        // Reset state
        tick(3);
        check_outputs_a("reset", 0, 0, 0, 0, 0);
        check_outputs_b("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Synchronous square wave, 3 high / 5 low: 5 periods -> 4 results
        restart();
        repeat (5) drive_period(3, 5);
        tick(8);
        check("sq_a_count", qa.size(), 4);
        check("sq_b_count", qb.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < qa.size()) begin
                check_rec("sq_a", qa[i], 3, 5, 8, 0);
                check("sq_a_latency", qa[i].cyc, rise_q[i + 1] + 2);
                if (i > 0) check("sq_a_spacing", qa[i].cyc - qa[i - 1].cyc, 8);
            end
            if (i < qb.size()) begin
                check_rec("sq_b", qb[i], 3, 5, 8, 0);
                check("sq_b_latency", qb[i].cyc, rise_q[i + 1] + 3);
            end
        end

        // Odd divide-by-7: posedge phase high 3 of 7, ORed with its negedge copy
        restart();
        p_ph = 1'b0;
        n_ph = 1'b0;
        for (int i = 0; i < 42; i++) begin
            @(posedge clk);
            #1;
            p_ph   = ((i % 7) < 3);
            sig_in = p_ph | n_ph;
            @(negedge clk);
            n_ph   = p_ph;
            sig_in = p_ph | n_ph;
        end
        tick(8);
        check("div7_a_count", qa.size(), 5);
        check("div7_b_count", qb.size(), 5);
        foreach (qa[i]) begin
            check("div7_a_period", qa[i].p, 7);
            check("div7_a_high_3or4", int'(qa[i].h == 3 || qa[i].h == 4), 1);
            check("div7_a_sum", qa[i].h + qa[i].l, 7);
        end
        foreach (qb[i]) begin
            check("div7_b_period", qb[i].p, 7);
            check("div7_b_high_3or4", int'(qb[i].h == 3 || qb[i].h == 4), 1);
        end

        // Saturation: 4-bit instance saturates the 20-cycle high phase
        restart();
        drive_period(3, 3);
        drive_period(20, 2);
        drive_period(3, 3);
        drive_period(3, 3);
        tick(8);
        check("sat_b_count", qb.size(), 3);
        check("sat_a_count", qa.size(), 3);
        if (qb.size() == 3) begin
            check_rec("sat_b_first", qb[0], 3, 3, 6, 0);
            check_rec("sat_b_long", qb[1], 15, 2, 17, 1);
            check_rec("sat_b_after", qb[2], 3, 3, 6, 0);
        end
        if (qa.size() == 3) begin
            check_rec("sat_a_long", qa[1], 20, 2, 22, 0);
        end

        // Abort during MEAS_LOW, then re-enable
        restart();
        repeat (3) drive_period(3, 5);
        sig_in = 1'b1;
        tick(3);
        sig_in = 1'b0;
        tick(4);
        meas_en = 1'b0;
        tick(2);
        sig_in = 1'b1;
        tick(3);
        sig_in = 1'b0;
        tick(3);
        check("abort_a_count", qa.size(), 3);
        check("abort_b_count", qb.size(), 3);
        check_outputs_a("abort_hold", 3, 5, 8, 0, 0);
        check_outputs_b("abort_hold", 3, 5, 8, 0, 0);
        meas_en = 1'b1;
        tick(2);
        drive_period(2, 4);
        drive_period(2, 4);
        tick(8);
        check("reen_a_count", qa.size(), 4);
        check("reen_b_count", qb.size(), 4);
        if (qa.size() == 4) begin
            check_rec("reen_a", qa[3], 2, 4, 6, 0);
            check("reen_a_latency", qa[3].cyc, rise_q[4] + 2);
        end
        if (qb.size() == 4) begin
            check_rec("reen_b", qb[3], 2, 4, 6, 0);
            check("reen_b_latency", qb[3].cyc, rise_q[4] + 3);
        end

        // Reset pulse while in MEAS_HIGH
        restart();
        drive_period(3, 5);
        sig_in = 1'b1;
        tick(4);
        check("rstmid_a_pre", qa.size(), 1);
        sig_in = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_outputs_a("rstmid", 0, 0, 0, 0, 0);
        check_outputs_b("rstmid", 0, 0, 0, 0, 0);
        tick(3);
        drive_period(4, 2);
        drive_period(4, 2);
        tick(8);
        check("rstmid_a_count", qa.size(), 2);
        check("rstmid_b_count", qb.size(), 2);
        if (qa.size() == 2) begin
            check_rec("rstmid_a", qa[1], 4, 2, 6, 0);
            check("rstmid_a_latency", qa[1].cyc, rise_q[2] + 2);
        end
        if (qb.size() == 2) begin
            check_rec("rstmid_b", qb[1], 4, 2, 6, 0);
            check("rstmid_b_latency", qb[1].cyc, rise_q[2] + 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
